// File: rtl/audio_pkg.sv
// Shared audio-path types: stereo sample layout, DAC feeder FSM states and defaults.
package audio_pkg;

    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } sample_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        WRITE,
        HOLD
    } dac_state_t;

    localparam int unsigned DAC_FIFO_DEPTH_DEFAULT = 8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy counter; pointers wrap modulo DEPTH, the level tells full from empty.
module sample_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Requests against a full/empty FIFO are dropped here so callers need no guard.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dac_feeder.sv
// Buffers producer samples and strobes them into the codec DAC FIFO, filling and counting on underrun.
module dac_feeder
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH         = DAC_FIFO_DEPTH_DEFAULT,
    parameter bit          UNDERRUN_ZERO = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   AUD_INIT_FINISH,
    input  logic                   AUD_DAC_FULL,
    input  logic [31:0]            SAMPLE_DATA,
    input  logic                   SAMPLE_VALID,
    output logic                   SAMPLE_READY,
    output logic [31:0]            DACDATA,
    output logic                   DAC_WRITE,
    output logic [$clog2(DEPTH):0] FIFO_LEVEL,
    output logic [15:0]            UNDERRUN_COUNT
);

    dac_state_t  state_q, state_d;
    sample_t     dac_q, dac_d;
    sample_t     last_q, last_d;
    logic [15:0] underrun_q, underrun_d;

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [31:0] fifo_rdata;
    sample_t     fill_sample;
    logic        dac_write;

    assign SAMPLE_READY = !fifo_full;
    assign fifo_push    = SAMPLE_VALID && !fifo_full;
    assign fill_sample  = UNDERRUN_ZERO ? sample_t'('0) : last_q;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(sample_t))
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .push_i  (fifo_push),
        .wdata_i (SAMPLE_DATA),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (FIFO_LEVEL)
    );

    always_comb begin
        state_d    = state_q;
        dac_d      = dac_q;
        last_d     = last_q;
        underrun_d = underrun_q;
        fifo_pop   = 1'b0;
        dac_write  = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!AUD_DAC_FULL) begin
                    state_d = WRITE;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        dac_d    = sample_t'(fifo_rdata);
                    end else begin
                        dac_d      = fill_sample;
                        underrun_d = sat_inc16(underrun_q);
                    end
                end
            end
            WRITE: begin
                dac_write = 1'b1;
                last_d    = dac_q;
                state_d   = HOLD;
            end
            HOLD: begin
                state_d = WAIT;
            end
        endcase

        // Losing codec init cancels any in-flight write; a popped sample is simply dropped.
        if (!AUD_INIT_FINISH) begin
            state_d    = IDLE;
            dac_d      = dac_q;
            last_d     = last_q;
            underrun_d = underrun_q;
            fifo_pop   = 1'b0;
            dac_write  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            dac_q      <= '0;
            last_q     <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            dac_q      <= dac_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    assign DACDATA        = dac_q;
    assign DAC_WRITE      = dac_write;
    assign UNDERRUN_COUNT = underrun_q;

endmodule

// File: doc/dac_feeder.md
Name: dac_feeder

Overview:
- Playback-side counterpart of the ADC capture path. Accepts 32-bit stereo samples ({left[31:16], right[15:0]}) from the synth/effects logic through a valid/ready handshake and buffers them in a small FIFO.
- Pushes samples to the audio codec interface's DAC FIFO as one-cycle write strobes whenever that FIFO is not full.
- When the buffer runs dry, it substitutes a fill sample and counts the underrun.

Parameters:
- DEPTH, 8, internal sample FIFO depth; power of two, minimum 2.
- UNDERRUN_ZERO, 1, fill sample on underrun: 1 = 32'h0, 0 = repeat the last sample written.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET_N  input  1  asynchronous active-low reset.
- AUD_INIT_FINISH  input  1  codec configuration complete; no DAC writes while low.
- AUD_DAC_FULL  input  1  codec DAC FIFO full; no DAC_WRITE may be issued while high.
- SAMPLE_DATA  input  32  sample from producer.
- SAMPLE_VALID  input  1  producer has a sample.
- SAMPLE_READY  output  1  block can accept; equals !fifo_full (combinational from registered count).
- DACDATA  output  32  sample presented to codec; registered.
- DAC_WRITE  output  1  one-cycle strobe; codec captures DACDATA on this cycle.
- FIFO_LEVEL  output  $clog2(DEPTH)+1  current internal occupancy.
- UNDERRUN_COUNT  output  16  underrun events since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (RESET_N low, async):
  - FIFO empty; FIFO_LEVEL=0; SAMPLE_READY=1.
  - DACDATA=0; DAC_WRITE=0; UNDERRUN_COUNT=0; last-sample register=0.
  - FSM enters IDLE.
- Producer side:
  - Push on posedge when SAMPLE_VALID && SAMPLE_READY.
  - Pushes are accepted in every FSM state, including IDLE.
  - While full, SAMPLE_READY=0; SAMPLE_DATA is ignored and the producer must hold it.
- FSM states:
  - IDLE: DAC_WRITE=0. Go to WAIT when AUD_INIT_FINISH=1.
  - WAIT: if AUD_DAC_FULL=0, go to WRITE. Stay in WAIT otherwise.
    - FIFO non-empty: pop the head into DACDATA.
    - FIFO empty: load the fill sample into DACDATA and increment UNDERRUN_COUNT (saturating).
  - WRITE: DAC_WRITE=1 for exactly this cycle. Update the last-sample register from DACDATA. Go to HOLD.
  - HOLD: DAC_WRITE=0. One-cycle guard for the codec's registered full flag. Go to WAIT.
- Latency: a sample pushed into an empty FIFO while in WAIT with AUD_DAC_FULL=0 appears with DAC_WRITE 2 cycles later (push edge, then pop edge into WRITE). There is no same-cycle bypass.
  - If the WAIT decision sees the FIFO empty in the push cycle, a fill sample goes first.
- Maximum DAC rate: one write per 3 cycles (WAIT->WRITE->HOLD).
- Simultaneous push and pop: level unchanged; data order preserved.
  - Push while full is impossible (READY low).
  - Pop while empty is replaced by the fill path.
- FIFO pointers wrap modulo DEPTH; the level counter distinguishes full from empty.
- AUD_INIT_FINISH falls in any state:
  - Next state is IDLE; DAC_WRITE forced 0 the same cycle (gated combinationally by AUD_INIT_FINISH).
  - A sample already popped into DACDATA is discarded and not re-queued.
  - FIFO contents are retained.
- AUD_DAC_FULL rising during WRITE has no effect; the strobe completes.
- UNDERRUN_COUNT holds at 16'hFFFF once saturated.

Decomposition:
- audio_pkg holds:
  - sample_t (32-bit packed struct {logic [15:0] left; logic [15:0] right}), shared with the ADC capture path.
  - dac_state_t enum {IDLE, WAIT, WRITE, HOLD}.
  - DAC_FIFO_DEPTH_DEFAULT = 8.
- One sub-module, sample_fifo: a synchronous FIFO with push/pop/full/empty/level, parameterised by DEPTH and width, reusable on the capture side.
- FSM, fill logic and counter stay in dac_feeder.

Test Plan:
- Reset, then AUD_INIT_FINISH=1, AUD_DAC_FULL=0, push 32'h1234_5678 once -> fill writes before the push: DACDATA=0 with DAC_WRITE, UNDERRUN_COUNT increments. Then DACDATA=32'h1234_5678 with DAC_WRITE exactly 2 cycles after the push edge; writes spaced ≥3 cycles.
- Push 8 samples (8'h01..8'h08 in the low byte) while AUD_INIT_FINISH=0 -> FIFO_LEVEL=8, SAMPLE_READY=0, 9th sample not accepted. After init rises, writes occur in order 01..08 and FIFO_LEVEL returns to 0.
- Hold AUD_DAC_FULL=1 for 20 cycles with FIFO non-empty -> zero DAC_WRITE pulses, FIFO_LEVEL constant. After release, the first write occurs 2 cycles later.
- UNDERRUN_ZERO=0, last written 32'hAAAA_5555, FIFO empty, AUD_DAC_FULL=0 -> DACDATA=32'hAAAA_5555 repeats on each write and UNDERRUN_COUNT increments by 1 per write. Force the count to 16'hFFFF -> it stays at 16'hFFFF.
- Drop AUD_INIT_FINISH during WRITE -> DAC_WRITE=0 that cycle, FSM in IDLE next cycle, remaining FIFO entries preserved and delivered after init returns.
- Assert RESET_N low asynchronously mid-stream (between clock edges) -> all outputs immediately at reset values (FIFO_LEVEL=0, DAC_WRITE=0, DACDATA=0, UNDERRUN_COUNT=0).
